// File: rtl/link_reset_sequencer.sv
// Link bring-up reset sequencer: PLL reset, lock wait, LOS-filtered link wait, delayed release.
// Define LINK_RSEQ_LOS_COUNTER_EN to build the filtered-LOS rising-edge counter.
module link_reset_sequencer #(
    parameter int unsigned G_HOLD_CYCLES  = 1000,
    parameter int unsigned G_LOCK_TIMEOUT = 100000,
    parameter int unsigned G_LOS_FILTER   = 16
) (
    input  logic        clk_ik,
    input  logic        rstn_ia,
    input  logic        ext_pll_ready_ia,
    input  logic        gbt_pll_locked_ia,
    input  logic        los_ia,
    output logic        pll_reset_o,
    output logic        sys_reset_o,
    output logic        ready_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_count_o,
    output logic [15:0] los_count_o
);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_EXT  = 3'd1,
        S_WAIT_GBT  = 3'd2,
        S_WAIT_LINK = 3'd3,
        S_DELAY     = 3'd4,
        S_RUN       = 3'd5
    } state_t;

    localparam logic [23:0] HOLD_LAST = 24'(G_HOLD_CYCLES - 1);
    localparam logic [23:0] TMO_LAST  = 24'(G_LOCK_TIMEOUT - 1);
    localparam logic [7:0]  FLT_LAST  = 8'(G_LOS_FILTER - 1);

    logic [2:0]  sync1_q, sync2_q;
    logic        ext_s, lock_s, los_s;
    logic        los_filt_q;
    logic [7:0]  flt_cnt_q;
    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        retry_inc;
    logic [7:0]  retry_q;
    logic        pll_reset_q, sys_reset_q, ready_q;

    // Bit order in the synchroniser: {ext_pll_ready, gbt_pll_locked, los}.
    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {ext_pll_ready_ia, gbt_pll_locked_ia, los_ia};
            sync2_q <= sync1_q;
        end
    end

    assign ext_s  = sync2_q[2];
    assign lock_s = sync2_q[1];
    assign los_s  = sync2_q[0];

    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            los_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else if (los_s == los_filt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FLT_LAST) begin
            los_filt_q <= los_s;
            flt_cnt_q  <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        case (state_q)
            S_HOLD:      if (cnt_q == HOLD_LAST) state_d = S_WAIT_EXT;
            S_WAIT_EXT:  if (ext_s) state_d = S_WAIT_GBT;
            S_WAIT_GBT: begin
                if (lock_s) begin
                    state_d = S_WAIT_LINK;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = S_HOLD;
                    retry_inc = 1'b1;
                end
            end
            S_WAIT_LINK: if (!los_filt_q) state_d = S_DELAY;
            S_DELAY:     if (cnt_q == HOLD_LAST) state_d = S_RUN;
            S_RUN:       state_d = S_RUN;
            default:     state_d = S_HOLD;
        endcase
        // Loss of a prerequisite overrides any normal progression, highest priority first.
        if ((state_q inside {S_WAIT_GBT, S_WAIT_LINK, S_DELAY, S_RUN}) && !ext_s) begin
            state_d   = S_HOLD;
            retry_inc = 1'b0;
        end else if ((state_q inside {S_WAIT_LINK, S_DELAY, S_RUN}) && !lock_s) begin
            state_d = S_HOLD;
        end else if ((state_q inside {S_DELAY, S_RUN}) && los_filt_q) begin
            state_d = S_WAIT_LINK;
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == 24'hFF_FFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // Output flops are loaded from the next state so they change together with state_q.
    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= (state_d == S_HOLD) || (state_d == S_WAIT_EXT);
            sys_reset_q <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
            if (retry_inc && (retry_q != 8'hFF)) begin
                retry_q <= retry_q + 8'd1;
            end
        end
    end

    assign pll_reset_o   = pll_reset_q;
    assign sys_reset_o   = sys_reset_q;
    assign ready_o       = ready_q;
    assign state_o       = state_q;
    assign retry_count_o = retry_q;

`ifdef LINK_RSEQ_LOS_COUNTER_EN
    logic        los_rise;
    logic [15:0] los_cnt_q;

    assign los_rise = los_s && !los_filt_q && (flt_cnt_q == FLT_LAST);

    always_ff @(posedge clk_ik or negedge rstn_ia) begin
        if (!rstn_ia) begin
            los_cnt_q <= '0;
        end else if (los_rise && (state_q inside {S_DELAY, S_RUN}) && (los_cnt_q != 16'hFFFF)) begin
            los_cnt_q <= los_cnt_q + 16'd1;
        end
    end

    assign los_count_o = los_cnt_q;
`else
    assign los_count_o = '0;
`endif

endmodule

// File: tb/tb_link_reset_sequencer.sv
// Bench for link_reset_sequencer: per-cycle reference model plus directed bring-up scenarios.
module tb_link_reset_sequencer;

  localparam int HOLD = 8;
  localparam int TMO  = 64;
  localparam int FLT  = 4;

  logic        clk_ik = 1'b0;
  logic        rstn_ia = 1'b0;
  logic        ext_pll_ready_ia = 1'b1;
  logic        gbt_pll_locked_ia = 1'b1;
  logic        los_ia = 1'b0;
  logic        pll_reset_o, sys_reset_o, ready_o;
  logic [2:0]  state_o;
  logic [7:0]  retry_count_o;
  logic [15:0] los_count_o;

  int checks = 0;
  int errors = 0;

  link_reset_sequencer #(
    .G_HOLD_CYCLES (HOLD),
    .G_LOCK_TIMEOUT(TMO),
    .G_LOS_FILTER  (FLT)
  ) dut (
    .clk_ik           (clk_ik),
    .rstn_ia          (rstn_ia),
    .ext_pll_ready_ia (ext_pll_ready_ia),
    .gbt_pll_locked_ia(gbt_pll_locked_ia),
    .los_ia           (los_ia),
    .pll_reset_o      (pll_reset_o),
    .sys_reset_o      (sys_reset_o),
    .ready_o          (ready_o),
    .state_o          (state_o),
    .retry_count_o    (retry_count_o),
    .los_count_o      (los_count_o)
  );

  // ---------------- clock ----------------
  always #5 clk_ik = ~clk_ik;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States numbered in bring-up order; "after X" means a higher number.
  int m_state = 0;
  int m_cis = 0;
  int m_retry = 0;
  int m_los_cnt = 0;
  bit m_filt = 1'b1;
  bit m_run_lvl = 1'b0;
  int m_run_len = 0;
  bit h_ext[$];
  bit h_lock[$];
  bit h_los[$];

  always @(posedge clk_ik or negedge rstn_ia) begin
    bit se, sk, sl, new_filt, inc;
    int nxt;
    if (!rstn_ia) begin
      m_state = 0; m_cis = 0; m_retry = 0; m_los_cnt = 0;
      m_filt = 1'b1; m_run_lvl = 1'b0; m_run_len = 0;
      h_ext.delete(); h_lock.delete(); h_los.delete();
    end else begin
      // Decisions see the input value sampled two edges earlier (zero before that).
      h_ext.push_back(ext_pll_ready_ia);
      h_lock.push_back(gbt_pll_locked_ia);
      h_los.push_back(los_ia);
      if (h_ext.size() > 3) begin
        void'(h_ext.pop_front()); void'(h_lock.pop_front()); void'(h_los.pop_front());
      end
      se = (h_ext.size() == 3) ? h_ext[0] : 1'b0;
      sk = (h_lock.size() == 3) ? h_lock[0] : 1'b0;
      sl = (h_los.size() == 3) ? h_los[0] : 1'b0;

      if (m_run_len > 0 && sl == m_run_lvl) m_run_len++;
      else begin m_run_lvl = sl; m_run_len = 1; end
      new_filt = (sl != m_filt && m_run_len >= FLT) ? sl : m_filt;

      m_cis++;
      nxt = m_state;
      inc = 1'b0;
      if (m_state >= 2 && !se) nxt = 0;
      else if (m_state >= 3 && !sk) nxt = 0;
      else if (m_state >= 4 && m_filt) nxt = 3;
      else begin
        case (m_state)
          0: if (m_cis == HOLD) nxt = 1;
          1: if (se) nxt = 2;
          2: if (sk) nxt = 3; else if (m_cis == TMO) begin nxt = 0; inc = 1'b1; end
          3: if (!m_filt) nxt = 4;
          4: if (m_cis == HOLD) nxt = 5;
          default: nxt = m_state;
        endcase
      end
`ifdef LINK_RSEQ_LOS_COUNTER_EN
      if (new_filt && !m_filt && m_state >= 4 && m_los_cnt < 65535) m_los_cnt++;
`endif
      if (inc && m_retry < 255) m_retry++;
      if (nxt != m_state) m_cis = 0;
      m_state = nxt;
      m_filt = new_filt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(posedge clk_ik);
    #1;
    check("state", 32'(state_o), 32'(m_state));
    check("pll_reset", 32'(pll_reset_o), 32'(m_state <= 1));
    check("sys_reset", 32'(sys_reset_o), 32'(m_state != 5));
    check("ready", 32'(ready_o), 32'(m_state == 5));
    check("retry_count", 32'(retry_count_o), 32'(m_retry));
    check("los_count", 32'(los_count_o), 32'(m_los_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_ik);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk_ik);
    rstn_ia = 1'b0;
    repeat (2) @(negedge clk_ik);
    rstn_ia = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int guard;
    int exp_los1;
`ifdef LINK_RSEQ_LOS_COUNTER_EN
    exp_los1 = 1;
`else
    exp_los1 = 0;
`endif
    repeat (3) @(negedge clk_ik);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pll", 32'(pll_reset_o), 32'd1);
    check("rst_sys", 32'(sys_reset_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_retry", 32'(retry_count_o), 32'd0);
    rstn_ia = 1'b1;

    // Clean bring-up: DELAY entered at edge 10, RUN at edge 18.
    cycles(18);
    check("bringup_delay", 32'(state_o), 32'd4);
    check("bringup_sys_held", 32'(sys_reset_o), 32'd1);
    cycles(1);
    check("bringup_run", 32'(state_o), 32'd5);
    check("bringup_ready", 32'(ready_o), 32'd1);
    check("bringup_sys", 32'(sys_reset_o), 32'd0);

    // LOS glitch shorter than the filter is ignored.
    repeat (3) @(negedge clk_ik);
    los_ia = 1'b1;
    repeat (3) @(negedge clk_ik);
    los_ia = 1'b0;
    repeat (12) @(negedge clk_ik);
    check("los3_run", 32'(state_o), 32'd5);
    check("los3_count", 32'(los_count_o), 32'd0);

    // Four-cycle LOS pulse: filter flips at edge a+5, FSM reacts at a+6.
    los_ia = 1'b1;
    repeat (4) @(negedge clk_ik);
    los_ia = 1'b0;
    cycles(2);
    check("los4_still_run", 32'(state_o), 32'd5);
    check("los4_count", 32'(los_count_o), 32'(exp_los1));
    cycles(1);
    check("los4_wait_link", 32'(state_o), 32'd3);
    check("los4_sys", 32'(sys_reset_o), 32'd1);
    cycles(14);
    check("los4_recover", 32'(state_o), 32'd5);

    // Simultaneous drop of ext ready and lock: HOLD two sync cycles later.
    @(negedge clk_ik);
    ext_pll_ready_ia = 1'b0;
    gbt_pll_locked_ia = 1'b0;
    cycles(2);
    check("drop_pre_state", 32'(state_o), 32'd5);
    check("drop_pre_pll", 32'(pll_reset_o), 32'd0);
    cycles(1);
    check("drop_hold", 32'(state_o), 32'd0);
    check("drop_pll", 32'(pll_reset_o), 32'd1);
    @(negedge clk_ik);
    ext_pll_ready_ia = 1'b1;
    gbt_pll_locked_ia = 1'b1;
    cycles(25);
    check("drop_recover", 32'(state_o), 32'd5);

    // Lock never arrives: first timeout at edge 72, then every 73 cycles.
    @(negedge clk_ik);
    gbt_pll_locked_ia = 1'b0;
    reset_pulse();
    cycles(72);
    check("tmo_wait_gbt", 32'(state_o), 32'd2);
    check("tmo_retry0", 32'(retry_count_o), 32'd0);
    cycles(1);
    check("tmo_hold", 32'(state_o), 32'd0);
    check("tmo_retry1", 32'(retry_count_o), 32'd1);
    guard = 0;
    while (retry_count_o != 8'd255 && guard < 20000) begin
      cycles(1);
      guard++;
    end
    check("tmo_retry_reach255", 32'(retry_count_o), 32'd255);
    cycles(200);
    check("tmo_retry_sat", 32'(retry_count_o), 32'd255);

    // Asynchronous reset in DELAY, then full restart.
    @(negedge clk_ik);
    gbt_pll_locked_ia = 1'b1;
    reset_pulse();
    cycles(11);
    check("areset_in_delay", 32'(state_o), 32'd4);
    @(negedge clk_ik);
    rstn_ia = 1'b0;
    #1;
    check("areset_state", 32'(state_o), 32'd0);
    check("areset_pll", 32'(pll_reset_o), 32'd1);
    check("areset_sys", 32'(sys_reset_o), 32'd1);
    check("areset_ready", 32'(ready_o), 32'd0);
    check("areset_retry", 32'(retry_count_o), 32'd0);
    repeat (2) @(negedge clk_ik);
    rstn_ia = 1'b1;
    cycles(18);
    check("restart_delay", 32'(state_o), 32'd4);
    cycles(1);
    check("restart_run", 32'(state_o), 32'd5);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_reset_sequencer.md
LINK_RESET_SEQUENCER -- requirements
Module: link_reset_sequencer

Interface
REQ-001 SHALL have parameter G_HOLD_CYCLES, default 1000, meaning clk_ik cycles that resets are held after entering S_HOLD and S_DELAY (range 2..2^20).
REQ-002 SHALL have parameter G_LOCK_TIMEOUT, default 100000, meaning maximum clk_ik cycles spent in S_WAIT_GBT before a retry (range 2..2^24).
REQ-003 SHALL have parameter G_LOS_FILTER, default 16, meaning consecutive cycles the synchronised los must hold a new level before the filtered value changes (range 1..255).
REQ-004 SHALL have port clk_ik, input, 1, 100 MHz free-running system clock.
REQ-005 SHALL have port rstn_ia, input, 1; the block has one clock, and its reset is asynchronous and active-low.
REQ-006 SHALL have port ext_pll_ready_ia, input, 1, asynchronous external PLL ready flag.
REQ-007 SHALL have port gbt_pll_locked_ia, input, 1, asynchronous 40 MHz GBT PLL lock flag.
REQ-008 SHALL have port los_ia, input, 1, asynchronous optical loss-of-signal, active high.
REQ-009 SHALL have port pll_reset_o, output, 1, active-high reset to the GBT 40 MHz PLL.
REQ-010 SHALL have port sys_reset_o, output, 1, active-high system reset, fed to the per-domain reset synchronisers.
REQ-011 SHALL have port ready_o, output, 1, high only in S_RUN.
REQ-012 SHALL have port state_o, output, 3, current FSM state encoding.
REQ-013 SHALL have port retry_count_o, output, 8, saturating count of lock timeouts.
REQ-014 SHALL have port los_count_o, output, 16, saturating count of filtered LOS rising edges.

Function
REQ-015 SHALL synchronise each *_ia input through two clk_ik flip-flops; all FSM decisions use synchronised values (2-cycle input latency).
REQ-016 SHALL filter synchronised los: the filtered value changes only after G_LOS_FILTER consecutive cycles at the opposite level; a glitch resets the filter counter.
REQ-017 SHALL implement states and encodings S_HOLD=0, S_WAIT_EXT=1, S_WAIT_GBT=2, S_WAIT_LINK=3, S_DELAY=4, S_RUN=5.
REQ-018 S_HOLD: pll_reset_o=1, sys_reset_o=1; SHALL advance to S_WAIT_EXT after exactly G_HOLD_CYCLES cycles.
REQ-019 S_WAIT_EXT: pll_reset_o=1, sys_reset_o=1; SHALL advance to S_WAIT_GBT on the first cycle ext_pll_ready is high.
REQ-020 S_WAIT_GBT: pll_reset_o=0, sys_reset_o=1; SHALL advance to S_WAIT_LINK when locked is high; SHALL return to S_HOLD and increment retry_count_o if G_LOCK_TIMEOUT cycles elapse first.
REQ-021 S_WAIT_LINK: pll_reset_o=0, sys_reset_o=1; SHALL advance to S_DELAY when filtered los is low.
REQ-022 S_DELAY: sys_reset_o=1; SHALL advance to S_RUN after G_HOLD_CYCLES cycles; a filtered los rise returns it to S_WAIT_LINK.
REQ-023 S_RUN: sys_reset_o=0, pll_reset_o=0, ready_o=1.
REQ-024 In every state after S_WAIT_EXT: ext_pll_ready low SHALL force S_HOLD; otherwise, in states after S_WAIT_GBT, locked low SHALL force S_HOLD; otherwise, in S_DELAY/S_RUN, filtered los high SHALL force S_WAIT_LINK. The listed priority applies to simultaneous events.
REQ-025 Outputs SHALL be registered and reflect the state entered, one cycle after the transition decision.
REQ-026 Counters SHALL saturate at all-ones and never wrap; the state counter clears on every state change.

Reset
REQ-027 While rstn_ia is low: state=S_HOLD, pll_reset_o=1, sys_reset_o=1, ready_o=0, counters=0, sync flops=0, filtered los=1; assertion takes effect asynchronously mid-operation, and deassertion resumes S_HOLD with a full G_HOLD_CYCLES count.

Configuration
REQ-028 With macro LINK_RSEQ_LOS_COUNTER_EN defined, los_count_o SHALL count filtered LOS rising edges while in S_DELAY or S_RUN; undefined, los_count_o SHALL be constant 0 and its counter SHALL not be synthesised.

Verification (G_HOLD_CYCLES=8, G_LOCK_TIMEOUT=64, G_LOS_FILTER=4)
REQ-029 All inputs good from reset release -> S_RUN and sys_reset_o=0 reached after 8+2+8 plus sync/transition cycles; ready_o=1.
REQ-030 locked held low -> S_HOLD re-entered every 8+64+ cycles; retry_count_o increments to 255 then stays.
REQ-031 In S_RUN, los pulse of 3 cycles -> no state change; a 4-cycle pulse -> S_WAIT_LINK, sys_reset_o=1, los_count_o=1 (macro defined) or 0 (undefined).
REQ-032 In S_RUN, ext_pll_ready and locked drop in the same cycle -> S_HOLD, pll_reset_o=1 two sync cycles later.
REQ-033 rstn_ia pulsed low in S_DELAY -> outputs immediately at reset values; after release, full sequence restarts from S_HOLD.
